// File: rtl/intt_out_buf_if.sv
// intt_out_buf_if: INTT dual-lane stream in, canonical coefficient stream out.
// master = INTT/consumer side, slave = the frame buffer.
interface intt_out_buf_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  in_en;
  logic [DATA_WIDTH-1:0] in [2];
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  err_abort;
  logic                  err_ovf;

  modport master (
    output in_en, in, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, err_abort, err_ovf
  );

  modport slave (
    input  in_en, in, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, err_abort, err_ovf
  );
endinterface

// File: rtl/intt_out_buf.sv
// intt_out_buf: ping-pong frame buffer behind the INTT,
// canonicalises to [0,Q) and replays in natural order.
module intt_out_buf #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int LOG_N      = 8
) (
  input  logic         clk,
  input  logic         rst,
  intt_out_buf_if.slave bus
);
  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int AW   = LOG_N - 1;
  localparam logic [DATA_WIDTH-1:0] QV = DATA_WIDTH'(Q);
  localparam logic [AW-1:0]    WLAST = AW'(HALF - 1);
  localparam logic [LOG_N-1:0] RLAST = LOG_N'(N - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;

  logic [DATA_WIDTH-1:0] r_lo [2][HALF];
  logic [DATA_WIDTH-1:0] r_hi [2][HALF];

  wstate_t r_wst, w_wst_nx;
  rstate_t r_rst, w_rst_nx;

  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_rel_bank;
  logic [AW-1:0]         r_wr_cnt;
  logic [LOG_N-1:0]      r_rd_cnt;
  logic                  r_in_ready;
  logic                  r_err_abort;
  logic                  r_err_ovf;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvld;
  logic                  r_rlast;
  logic [DATA_WIDTH-1:0] r_q [2];
  logic [1:0]            r_ql;
  logic [1:0]            r_cnt;

  logic [DATA_WIDTH-1:0] w_c0;
  logic [DATA_WIDTH-1:0] w_c1;
  logic                  w_wr_en;
  logic                  w_wr_done;
  logic                  w_abort;
  logic                  w_ovf;
  logic [1:0]            w_full_nx;
  logic                  w_wr_bank_nx;
  logic                  w_pop;
  logic                  w_rel;
  logic [1:0]            w_cnt_nx;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_rd_done;
  logic                  w_pidx;

  assign w_c0 = (bus.in[0] >= QV) ? bus.in[0] - QV : bus.in[0];
  assign w_c1 = (bus.in[1] >= QV) ? bus.in[1] - QV : bus.in[1];

  // write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wst <= W_IDLE;
    else     r_wst <= w_wst_nx;
  end

  // write FSM next state
  always_comb begin
    w_wst_nx = r_wst;
    unique case (r_wst)
      W_IDLE:
        if (bus.in_en)
          w_wst_nx = r_full[r_wr_bank] ? W_DROP : W_FILL;
      W_FILL:
        if (!bus.in_en || r_wr_cnt == WLAST)
          w_wst_nx = W_IDLE;
      W_DROP:
        if (!bus.in_en) w_wst_nx = W_IDLE;
      default: w_wst_nx = W_IDLE;
    endcase
  end

  // write FSM outputs: beat write, frame done, error strobes
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_done = 1'b0;
    w_abort   = 1'b0;
    w_ovf     = 1'b0;
    unique case (r_wst)
      W_IDLE: begin
        w_ovf   = bus.in_en & r_full[r_wr_bank];
        w_wr_en = bus.in_en & ~r_full[r_wr_bank];
      end
      W_FILL: begin
        w_wr_en   = bus.in_en;
        w_abort   = ~bus.in_en;
        w_wr_done = bus.in_en & (r_wr_cnt == WLAST);
      end
      default: ;
    endcase
  end

  // full flags after this cycle's fill and release
  always_comb begin
    w_full_nx = r_full;
    if (w_wr_done) w_full_nx[r_wr_bank] = 1'b1;
    if (w_rel)     w_full_nx[r_rel_bank] = 1'b0;
  end

  assign w_wr_bank_nx = r_wr_bank ^ w_wr_done;

  // bank bookkeeping, write counter, registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rel_bank  <= 1'b0;
      r_wr_cnt    <= '0;
      r_in_ready  <= 1'b1;
      r_err_abort <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_full      <= w_full_nx;
      r_wr_bank   <= w_wr_bank_nx;
      r_in_ready  <= ~w_full_nx[w_wr_bank_nx];
      r_err_abort <= w_abort;
      r_err_ovf   <= w_ovf;
      if (w_abort)      r_wr_cnt <= '0;
      else if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_rel)        r_rel_bank <= ~r_rel_bank;
    end
  end

  // bank storage and one-cycle synchronous read port
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_lo[r_wr_bank][r_wr_cnt] <= w_c0;
      r_hi[r_wr_bank][r_wr_cnt] <= w_c1;
    end
    if (w_issue)
      r_rdata <= r_rd_cnt[LOG_N-1]
               ? r_hi[r_rd_bank][r_rd_cnt[AW-1:0]]
               : r_lo[r_rd_bank][r_rd_cnt[AW-1:0]];
  end

  // reads are issued only if the skid stage can absorb them
  assign w_pop    = (r_cnt != 2'd0) & bus.out_ready;
  assign w_rel    = w_pop & r_ql[0];
  assign w_cnt_nx = r_cnt + {1'b0, r_rvld} - {1'b0, w_pop};
  assign w_room   = (w_cnt_nx <= 2'd1);

  // read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst <= R_IDLE;
    else     r_rst <= w_rst_nx;
  end

  // read FSM next state
  always_comb begin
    w_rst_nx = r_rst;
    unique case (r_rst)
      R_IDLE:
        if (r_full[r_rd_bank]) w_rst_nx = R_STREAM;
      R_STREAM:
        if (w_rd_done && !r_full[~r_rd_bank])
          w_rst_nx = R_IDLE;
    endcase
  end

  // read FSM outputs: address issue and end of frame
  always_comb begin
    w_issue = 1'b0;
    unique case (r_rst)
      R_IDLE:   w_issue = r_full[r_rd_bank] & w_room;
      R_STREAM: w_issue = w_room;
    endcase
    w_rd_done = w_issue & (r_rd_cnt == RLAST);
  end

  // read address, bank pointer and read-data valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_rvld    <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      r_rvld  <= w_issue;
      r_rlast <= w_rd_done;
      if (w_issue)   r_rd_cnt  <= r_rd_cnt + 1'b1;
      if (w_rd_done) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign w_pidx = (r_cnt == 2'd2) | ((r_cnt == 2'd1) & ~w_pop);

  // two-entry skid/output stage, head drives the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_ql   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_q[0]  <= r_q[1];
        r_ql[0] <= r_ql[1];
      end
      if (r_rvld) begin
        r_q[w_pidx]  <= r_rdata;
        r_ql[w_pidx] <= r_rlast;
      end
      r_cnt <= w_cnt_nx;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_data  = r_q[0];
  assign bus.out_last  = r_ql[0] & (r_cnt != 2'd0);
  assign bus.err_abort = r_err_abort;
  assign bus.err_ovf   = r_err_ovf;
endmodule

// File: tb/tb_intt_out_buf.sv
// tb_intt_out_buf: directed frames, canonicalisation,
// back-pressure, overflow, abort and mid-stream reset.
module tb_intt_out_buf;
  localparam int DW = 13;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   span;
  int   n;

  always #5 clk = ~clk;

  intt_out_buf_if #(.DATA_WIDTH(DW)) bus ();

  intt_out_buf #(
    .DATA_WIDTH(DW),
    .Q(3329),
    .LOG_N(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int in0_of(int kind, int k);
    case (kind)
      0: return k;
      1: return (k == 0) ? 3329 : (k == 1) ? 3328 : k + 3329;
      2: return 1000 + k;
      3: return 2000 + k + 3329;
      4: return 3100 + k;
      5: return 500 + k;
      6: return 50 + k;
      default: return 3000 + k;
    endcase
  endfunction

  function automatic int in1_of(int kind, int k);
    case (kind)
      0: return k + 128;
      1: return (k == 0) ? 6657 : (k == 1) ? 3330 : k + 128;
      2: return 1128 + k;
      3: return 2128 + k;
      4: return 3200 + k;
      5: return 600 + k;
      6: return 178 + k;
      default: return 3128 + k;
    endcase
  endfunction

  function automatic int exp_of(int kind, int i);
    case (kind)
      0: return i;
      1: begin
        if (i == 0)   return 0;
        if (i == 1)   return 3328;
        if (i == 128) return 3328;
        if (i == 129) return 1;
        return i;
      end
      2: return 1000 + i;
      3: return 2000 + i;
      6: return 50 + i;
      default: return 3000 + i;
    endcase
  endfunction

  task automatic send_frame(input int kind, input int nb);
    for (int k = 0; k < nb; k++) begin
      bus.in_en = 1'b1;
      bus.in[0] = DW'(in0_of(kind, k));
      bus.in[1] = DW'(in1_of(kind, k));
      tick();
    end
    bus.in_en = 1'b0;
  endtask

  task automatic drain(input int kind, input bit toggle,
                       output int sp);
    int idx = 0;
    int first = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    sp = -1;
    for (int cyc = 0; cyc < 2000 && idx < 256; cyc++) begin
      bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(held));
      end
      stalled = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("k%0d_data%0d", kind, idx),
            32'(bus.out_data), exp_of(kind, idx));
        chk($sformatf("k%0d_last%0d", kind, idx),
            32'(bus.out_last), 32'(idx == 255));
        if (idx == 0)   first = cyc;
        if (idx == 255) sp = cyc - first;
        idx++;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held    = bus.out_data;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    chk($sformatf("k%0d_count", kind), idx, 256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_en     = 1'b0;
    bus.in[0]     = '0;
    bus.in[1]     = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_abort", 32'(bus.err_abort), 0);
    chk("rst_ovf", 32'(bus.err_ovf), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b0;
    tick();

    send_frame(0, 128);
    chk("lat0", 32'(bus.out_valid), 0);
    tick();
    chk("lat1", 32'(bus.out_valid), 0);
    tick();
    chk("lat2", 32'(bus.out_valid), 1);
    chk("first_data", 32'(bus.out_data), 0);
    drain(0, 1'b0, span);
    chk("no_bubble_span", span, 255);

    send_frame(1, 128);
    drain(1, 1'b0, span);

    send_frame(2, 128);
    chk("rdy_after_A", 32'(bus.in_ready), 1);
    send_frame(3, 128);
    chk("rdy_after_B", 32'(bus.in_ready), 0);

    for (int k = 0; k < 128; k++) begin
      bus.in_en = 1'b1;
      bus.in[0] = DW'(in0_of(4, k));
      bus.in[1] = DW'(in1_of(4, k));
      tick();
      if (k == 0) begin
        chk("ovf_pulse", 32'(bus.err_ovf), 1);
        chk("ovf_no_abort", 32'(bus.err_abort), 0);
      end
      if (k == 1) chk("ovf_one_cycle", 32'(bus.err_ovf), 0);
    end
    bus.in_en = 1'b0;
    tick();
    chk("rdy_during_drop", 32'(bus.in_ready), 0);
    drain(2, 1'b1, span);
    drain(3, 1'b1, span);
    chk("rdy_after_drain", 32'(bus.in_ready), 1);

    send_frame(5, 50);
    tick();
    chk("abort_pulse", 32'(bus.err_abort), 1);
    tick();
    chk("abort_one_cycle", 32'(bus.err_abort), 0);
    chk("abort_no_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    send_frame(6, 128);
    drain(6, 1'b0, span);

    send_frame(0, 128);
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 98; c++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("pre_rst_count", n, 98);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_last", 32'(bus.out_last), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    send_frame(7, 128);
    drain(7, 1'b0, span);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
